// File: rtl/aes_iter_ctrl_if.sv
// Plaintext/key request and ciphertext response handshake for aes_iter_ctrl.
interface aes_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] pt_in;
  logic [0:127] key_in;
  logic [0:127] ct_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, pt_in, key_in, out_ready,
    input  in_ready, ct_out, out_valid
  );

  modport slave (
    input  in_valid, pt_in, key_in, out_ready,
    output in_ready, ct_out, out_valid
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 sequencer: feeds a combinational single-round datapath
// one round per clock and holds the ciphertext until the consumer takes it.
module aes_iter_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  aes_iter_ctrl_if.slave io,
  output logic          busy,
  output logic [0:127]  dp_state,
  output logic [0:RW-1] dp_round,
  output logic [0:127]  dp_key,
  input  logic [0:127]  dp_out,
  input  logic [0:127]  dp_key_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm, fsm_nx;
  logic [0:127]  state_r, state_nx;
  logic [0:127]  key_r, key_nx;
  logic [0:RW-1] rcnt, rcnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      state_r <= '0;
      key_r   <= '0;
      rcnt    <= '0;
    end else begin
      fsm     <= fsm_nx;
      state_r <= state_nx;
      key_r   <= key_nx;
      rcnt    <= rcnt_nx;
    end
  end

  always_comb begin
    fsm_nx   = fsm;
    state_nx = state_r;
    key_nx   = key_r;
    rcnt_nx  = rcnt;
    case (fsm)
      IDLE: begin
        if (io.in_valid && io.in_ready) begin
          state_nx = io.pt_in;
          key_nx   = io.key_in;
          rcnt_nx  = '0;
          fsm_nx   = RUN;
        end
      end
      RUN: begin
        state_nx = dp_out;
        // Round 0 is the bare AddRoundKey; the cipher key itself is round key 0.
        if (rcnt != '0) key_nx = dp_key_out;
        if (rcnt == RW'(NR)) fsm_nx = DONE;
        else                 rcnt_nx = rcnt + RW'(1);
      end
      DONE: begin
        if (io.out_ready) fsm_nx = IDLE;
      end
      default: fsm_nx = IDLE;
    endcase
  end

  assign io.in_ready  = (fsm == IDLE) && !rst;
  assign io.out_valid = (fsm == DONE);
  assign io.ct_out    = (fsm == DONE) ? state_r : '0;
  assign busy         = (fsm == RUN);

  assign dp_state = state_r;
  assign dp_key   = key_r;
  assign dp_round = rcnt;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl with a behavioural AES round datapath.
module tb_aes_iter_ctrl;

  typedef logic [0:127] blk_t;

  localparam blk_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam blk_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam blk_t B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam blk_t B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic         busy;
  logic [0:127] dp_state, dp_key, dp_out, dp_key_out;
  logic [0:4]   dp_round;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl #(.NR(10), .RW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .busy       (busy),
    .dp_state   (dp_state),
    .dp_round   (dp_round),
    .dp_key     (dp_key),
    .dp_out     (dp_out),
    .dp_key_out (dp_key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES round datapath model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'd254;
    logic [7:0] r1, r2, r3, r4;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    r1 = rl1(r); r2 = rl1(r1); r3 = rl1(r2); r4 = rl1(r3);
    return r ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int unsigned r);
    logic [7:0] rc = 8'h01;
    for (int unsigned i = 1; i < r; i++) rc = xt(rc);
    return rc;
  endfunction

  function automatic blk_t next_key(input blk_t k, input logic [7:0] rc);
    blk_t n;
    logic [0:31] t;
    t = {sb(k[104 +: 8]) ^ rc, sb(k[112 +: 8]), sb(k[120 +: 8]), sb(k[96 +: 8])};
    n[0  +: 32] = k[0  +: 32] ^ t;
    n[32 +: 32] = k[32 +: 32] ^ n[0  +: 32];
    n[64 +: 32] = k[64 +: 32] ^ n[32 +: 32];
    n[96 +: 32] = k[96 +: 32] ^ n[64 +: 32];
    return n;
  endfunction

  function automatic blk_t enc_round(input blk_t s, input logic last);
    logic [7:0] sx [16];
    logic [7:0] sh [16];
    logic [7:0] a0, a1, a2, a3;
    blk_t o;
    for (int unsigned i = 0; i < 16; i++) sx[i] = sb(s[8*i +: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sh[r + 4*c] = sx[r + 4*((c + r) % 4)];
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
      if (last) begin
        o[32*c +: 32] = {a0, a1, a2, a3};
      end else begin
        o[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return o;
  endfunction

  always_comb begin
    blk_t nk;
    nk         = '0;
    dp_out     = dp_state ^ dp_key;
    dp_key_out = dp_key;
    if (dp_round != 5'd0) begin
      nk         = next_key(dp_key, rcon(int'(dp_round)));
      dp_key_out = nk;
      dp_out     = enc_round(dp_state, dp_round == 5'd10) ^ nk;
    end
  end

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input blk_t pt, input blk_t k);
    int unsigned n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.in_valid = 1'b1;
    bus.pt_in    = pt;
    bus.key_in   = k;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.pt_in    = ~pt;
    bus.key_in   = ~k;
  endtask

  // lat counts cycles after the accept edge; the first call sample is cycle 'start'.
  task automatic wait_out(input int unsigned start, output int unsigned lat, output logic ok);
    lat = start;
    ok  = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (dp_round != 5'(lat - 1) || !busy || bus.in_ready) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy || bus.in_ready) ok = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ov_drop"}, 128'(bus.out_valid), 128'(1'b0));
    check({tag, "_idle_rdy"}, 128'(bus.in_ready), 128'(1'b1));
  endtask

  initial begin
    int unsigned lat;
    logic        ok;
    int unsigned na, no;
    int unsigned acc [2];
    blk_t        cts [2];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.pt_in     = '0;
    bus.key_in    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  128'(bus.in_ready),  128'(1'b0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_busy",      128'(busy),          128'(1'b0));
    check("rst_ct",        bus.ct_out,          128'(0));
    check("rst_round",     128'(dp_round),      128'(0));
    check("rst_state",     dp_state,            128'(0));
    check("rst_key",       dp_key,              128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(bus.in_ready), 128'(1'b1));

    // FIPS-197 C.1 with latency, then backpressure
    send(C1_PT, C1_KEY);
    wait_out(1, lat, ok);
    check("c1_latency", 128'(lat), 128'(12));
    check("c1_ct",      bus.ct_out, C1_CT);
    check("c1_rounds",  128'(ok), 128'(1'b1));
    ok = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ct_out !== C1_CT || bus.in_ready || busy || !bus.out_valid) ok = 1'b0;
    end
    check("bp_hold", 128'(ok), 128'(1'b1));
    consume("bp");

    // FIPS-197 Appendix B with round stepping
    send(B_PT, B_KEY);
    wait_out(1, lat, ok);
    check("b_latency", 128'(lat), 128'(12));
    check("b_ct",      bus.ct_out, B_CT);
    check("b_rounds",  128'(ok), 128'(1'b1));
    consume("b");

    // in_valid pulsed during RUN must be ignored
    send(C1_PT, C1_KEY);
    bus.in_valid = 1'b1;
    bus.pt_in    = B_PT;
    bus.key_in   = B_KEY;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(2, lat, ok);
    check("rej_latency", 128'(lat), 128'(12));
    check("rej_ct",      bus.ct_out, C1_CT);
    check("rej_rounds",  128'(ok), 128'(1'b1));
    consume("rej");
    send(B_PT, B_KEY);
    wait_out(1, lat, ok);
    check("rej2_ct", bus.ct_out, B_CT);
    consume("rej2");

    // Reset at round 5 aborts the operation
    send(C1_PT, C1_KEY);
    for (int unsigned n = 0; n < 20 && dp_round != 5'd5; n++) @(negedge clk);
    check("mid_round5", 128'(dp_round), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    check("mid_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("mid_busy",      128'(busy),          128'(1'b0));
    check("mid_round",     128'(dp_round),      128'(0));
    check("mid_in_ready",  128'(bus.in_ready),  128'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    send(C1_PT, C1_KEY);
    wait_out(1, lat, ok);
    check("post_rst_ct", bus.ct_out, C1_CT);
    consume("post_rst");

    // Back-to-back with in_valid and out_ready held high
    na = 0; no = 0;
    acc[0] = 0; acc[1] = 0;
    cts[0] = '0; cts[1] = '0;
    bus.in_valid  = 1'b1;
    bus.pt_in     = C1_PT;
    bus.key_in    = C1_KEY;
    bus.out_ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 60 && no < 2; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (na == 1) begin
        bus.pt_in  = B_PT;
        bus.key_in = B_KEY;
      end else if (na == 2) begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready && na < 2) begin
        acc[na] = cyc;
        na++;
      end
      if (bus.out_valid) begin
        cts[no] = bus.ct_out;
        no++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_accepts",  128'(na), 128'(2));
    check("b2b_interval", 128'(acc[1] - acc[0]), 128'(13));
    check("b2b_ct0",      cts[0], C1_CT);
    check("b2b_ct1",      cts[1], B_CT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
- Iterative AES-128 encryption sequencer that sits directly upstream of the single-round combinational datapath `top`.
- Accepts a plaintext/key pair over a valid/ready handshake and drives the datapath's `in`, `round` and `key` inputs for rounds 0..NR, one round per clock.
- Registers the datapath's `out` and `key_out` each cycle and presents the ciphertext over a valid/ready output handshake.
- The datapath is combinational; all state lives in this block.

Parameters:
- NR, 10, number of AES rounds after the initial AddRoundKey. Round counter runs 0..NR; fixed at 10 for AES-128.
- RW, 5, width of the round index. Matches the datapath `round` port.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  plaintext/key available
- in_ready  output  1  block idle and able to accept
- pt_in  input  [0:127]  plaintext; byte 0 = bits 0..7
- key_in  input  [0:127]  cipher key
- ct_out  output  [0:127]  ciphertext
- out_valid  output  1  ct_out valid
- out_ready  input  1  consumer accepts ct_out
- busy  output  1  rounds in progress
- dp_state  output  [0:127]  to datapath `in`
- dp_round  output  [0:RW-1]  to datapath `round`
- dp_key  output  [0:127]  to datapath `key`
- dp_out  input  [0:127]  from datapath `out`
- dp_key_out  input  [0:127]  from datapath `key_out`

Behaviour:
- Registers:
  - state_r[128], key_r[128], rcnt[RW], fsm in {IDLE, RUN, DONE}.
  - dp_state = state_r, dp_key = key_r, dp_round = rcnt (all direct from registers).
- Reset (rst high at a clock edge):
  - fsm=IDLE; state_r, key_r and rcnt all cleared to 0.
  - out_valid=0, busy=0, ct_out=0.
  - in_ready is forced 0 while rst is high.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_r<=pt_in, key_r<=key_in, rcnt<=0, fsm<=RUN.
- RUN (busy=1, in_ready=0):
  - Every cycle: state_r<=dp_out.
  - key_r<=dp_key_out only when rcnt>=1. At rcnt=0 the datapath returns pt^key and key_r keeps the cipher key.
  - If rcnt<NR: rcnt<=rcnt+1. If rcnt==NR: fsm<=DONE and rcnt holds at NR (no wrap).
- DONE:
  - out_valid=1, ct_out=state_r, busy=0, in_ready=0.
  - ct_out must stay stable while out_ready=0; there is no timeout.
  - On out_ready: fsm<=IDLE and out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle T; RUN occupies T+1..T+NR+1.
  - out_valid is first high in cycle T+NR+2 (T+12 for NR=10).
  - Minimum accept-to-accept interval is NR+3 cycles when out_ready is tied high.
- Datapath contract: at round NR the datapath omits MixColumns (FIPS-197 final round). The datapath carries this fix.
- Boundary conditions:
  - in_valid during RUN/DONE is ignored and not latched; pt_in/key_in are sampled only on the accept edge.
  - Input changes after accept have no effect.
  - rst in any state aborts immediately: no out_valid, and the partial state is discarded.
  - out_ready high outside DONE has no effect.
  - in_valid and out_ready both high in DONE: only the output completes; the input is accepted no earlier than the following IDLE cycle.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 12 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. dp_round must step 0,1,...,10 on consecutive cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ct_out stable, in_ready=0, busy=0. Release -> IDLE after 1 cycle.
- Busy rejection: pulse in_valid with a second vector during RUN -> not latched; first ct unchanged. Vector re-presented in IDLE -> correct second ct.
- Reset mid-op: assert rst at rcnt=5 -> next cycle out_valid=0, busy=0, dp_round=0. Fresh C.1 run afterwards yields 69c4e0d8....
- Back-to-back: out_ready and in_valid tied high, two vectors -> both cts correct, accept interval 13 cycles.
